axil_slave_regs: RTL and testbench
==================================

# axil_slave_regs

AXI4-Lite responder (slave) exposing a bank of NUM_REGS 32-bit registers. It is the target-side counterpart of the AXI-Lite initiator driven through the app_* request interface. In the subsystem it terminates the axi_* bus and presents register contents plus per-register write pulses to application logic. The write and read paths are independent and can run concurrently.

## Interface

Parameters:
- NUM_REGS, 16: number of 32-bit registers; power of 2, from 2 to 256.
- BASE_ADDR, 32'h0000_0000: byte address of register 0; aligned to NUM_REGS*4.

Ports:
- aclk in 1: the single clock; all logic is on the rising edge.
- areset in 1: reset, synchronous, active-high.
- axi_awaddr in 32 / axi_awprot in 3 / axi_awvalid in 1 / axi_awready out 1: write-address channel. awprot is ignored.
- axi_wdata in 32 / axi_wstrb in 4 / axi_wvalid in 1 / axi_wready out 1: write-data channel.
- axi_bresp out 2 / axi_bvalid out 1 / axi_bready in 1: write-response channel.
- axi_araddr in 32 / axi_arprot in 3 / axi_arvalid in 1 / axi_arready out 1: read-address channel. arprot is ignored.
- axi_rdata out 32 / axi_rresp out 2 / axi_rvalid out 1 / axi_rready in 1: read-data channel.
- regs_o out NUM_REGS*32: register contents; register i is at bits [32i+31:32i].
- wr_pulse_o out NUM_REGS: one-cycle pulse for each register that was written.

## Operation

- **Decode**
  - off = addr - BASE_ADDR.
  - In range when off < NUM_REGS*4.
  - idx = off[2 +: log2(NUM_REGS)]; addr[1:0] is ignored.
  - Out of range gives resp SLVERR (2'b10); in range gives OKAY (2'b00).
- **Write path**
  - Holding flags aw_held and w_held, with captured awaddr, wdata and wstrb.
  - axi_awready = !aw_held && !axi_bvalid; axi_wready = !w_held && !axi_bvalid.
  - AW and W may arrive in either order or in the same cycle.
  - Commit edge: the edge where (aw_held or AW handshake) and (w_held or W handshake) both hold.
  - At the commit edge:
    - if in range, update byte k of reg[idx] where wstrb[k]=1;
    - set axi_bvalid=1 and bresp;
    - clear both held flags.
  - wstrb=0: no data change; OKAY and the pulse are still issued.
  - Out of range: no register changes and no pulse.
  - bvalid and bresp stay stable until the edge where bready=1, then bvalid clears.
- **Read path**
  - axi_arready = !axi_rvalid.
  - On an AR handshake edge: rdata = reg[idx] (0 if out of range), rresp as decoded, rvalid=1.
  - rdata, rresp and rvalid stay stable until the rready edge.
- **Simultaneous access:** a read and a write committing on the same edge to the same register returns the pre-write value.
- **Reset (any time, including mid-transaction)**
  - All registers = 0; held flags cleared.
  - bvalid=0, rvalid=0, bresp=0, rresp=0, rdata=0, wr_pulse_o=0.
  - Ready outputs are 1 in the first cycle after reset.
  - Outstanding transactions are dropped.

## Timing

- Write latency: bvalid and the new regs_o value are visible in the cycle after the commit edge.
- wr_pulse_o[idx] is high for exactly that same cycle.
- Read latency: rvalid is high in the cycle after the AR handshake.
- Throughput, best case with bready and rready held high: one write per 2 cycles and one read per 2 cycles. Ready drops while a response is pending.
- A single AW or W may be held indefinitely while its partner is absent; the other channel's ready then stays high.
- No combinational path from any valid/ready input to any output, except the ready outputs, which depend only on registered state.

## Structure

- Package axil_pkg holds:
  - RESP_OKAY = 2'b00 and RESP_SLVERR = 2'b10;
  - AXIL_ADDR_W = 32 and AXIL_DATA_W = 32;
  - a function computing the register index from an address.
- Sub-module axil_reg_bank provides NUM_REGS×32 storage with a byte-strobed write port (we, idx, data, strb), a combinational read port, and pulse generation.
- The top level contains the decode, the AW/W holding registers and both channel FSMs.

## Test plan

- **Same-cycle write then read:** AW=0x8 and W=0xDEADBEEF with strb=4'hF in the same cycle, bready=1, then read 0x8.
  - Required: bvalid the next cycle with OKAY; wr_pulse_o[2] high for 1 cycle; rdata=0xDEADBEEF with OKAY.
- **W before AW, partial strobe:** W (0x11223344, strb=4'b0101) 3 cycles before AW 0x0.
  - Required: awready stays 1 and wready stays 0 while W is held; reg0 becomes 0x00220044 starting from 0.
- **Out of range:** write to 0x40 with NUM_REGS=16.
  - Required: bresp=SLVERR; no pulse; all registers unchanged.
  - Then read 0x40: rdata=0 with rresp=SLVERR.
- **Backpressure:** bready=0 for 5 cycles.
  - Required: bvalid and bresp stable throughout; awready and wready stay 0; a new AW is accepted only after the bready edge.
  - Same check on the read path with rready=0.
- **Collision:** reg3=0x5, then write 0x9 to reg3 committing on the same edge as a read of reg3.
  - Required: rdata=0x5; a subsequent read returns 0x9.
- **Reset mid-transaction:** assert areset with AW held and rvalid pending.
  - Required: all outputs at reset values the next cycle; the following write completes normally.

Source files
------------

// File: rtl/axil_pkg.sv
// Shared AXI4-Lite constants and address helpers for the register-slave slice.
package axil_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    localparam int AXIL_ADDR_W = 32;
    localparam int AXIL_DATA_W = 32;
    localparam int AXIL_STRB_W = AXIL_DATA_W / 8;

    // Widest register index supported (256 registers).
    localparam int MAX_IDX_W = 8;

    // Word index of an address relative to the bank base; callers truncate to their own width.
    function automatic logic [MAX_IDX_W-1:0] reg_index(
        input logic [AXIL_ADDR_W-1:0] addr,
        input logic [AXIL_ADDR_W-1:0] base
    );
        return MAX_IDX_W'((addr - base) >> 2);
    endfunction

    function automatic logic addr_in_range(
        input logic [AXIL_ADDR_W-1:0] addr,
        input logic [AXIL_ADDR_W-1:0] base,
        input logic [AXIL_ADDR_W-1:0] span
    );
        return (addr - base) < span;
    endfunction

endpackage

// File: rtl/axil_reg_bank.sv
// NUM_REGS x 32-bit register storage with a byte-strobed write port, a combinational
// read port and a one-cycle per-register write pulse aligned with the updated contents.
module axil_reg_bank
    import axil_pkg::*;
#(
    parameter int NUM_REGS = 16,
    parameter int IDX_W    = $clog2(NUM_REGS)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     we,
    input  logic [IDX_W-1:0]         idx,
    input  logic [AXIL_DATA_W-1:0]   data,
    input  logic [AXIL_STRB_W-1:0]   strb,
    input  logic [IDX_W-1:0]         rd_idx,
    output logic [AXIL_DATA_W-1:0]   rd_data,
    output logic [NUM_REGS*32-1:0]   regs,
    output logic [NUM_REGS-1:0]      wr_pulse
);

    logic [AXIL_DATA_W-1:0] mem [NUM_REGS];

    // NOTE: these are architecturally visible registers, not a RAM, so every entry is
    // cleared on reset; that also keeps this array in flops rather than a memory macro.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                mem[i] <= '0;
            end
            wr_pulse <= '0;
        end else begin
            wr_pulse <= '0;
            if (we) begin
                wr_pulse[idx] <= 1'b1;
                for (int k = 0; k < AXIL_STRB_W; k++) begin
                    if (strb[k]) begin
                        mem[idx][8*k +: 8] <= data[8*k +: 8];
                    end
                end
            end
        end
    end

    // Reading before the clock edge gives the pre-write value on a same-edge collision.
    always_comb begin
        rd_data = mem[rd_idx];
    end

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_flat
        assign regs[32*g +: 32] = mem[g];
    end

endmodule

// File: rtl/axil_slave_regs.sv
// AXI4-Lite slave terminating the axi_* bus onto a register bank; independent write
// (AW/W/B) and read (AR/R) paths with one outstanding transaction each.
module axil_slave_regs
    import axil_pkg::*;
#(
    parameter int                     NUM_REGS  = 16,
    parameter logic [AXIL_ADDR_W-1:0] BASE_ADDR = 32'h0000_0000
) (
    input  logic                   aclk,
    input  logic                   areset,

    input  logic [AXIL_ADDR_W-1:0] axi_awaddr,
    input  logic [2:0]             axi_awprot,
    input  logic                   axi_awvalid,
    output logic                   axi_awready,

    input  logic [AXIL_DATA_W-1:0] axi_wdata,
    input  logic [AXIL_STRB_W-1:0] axi_wstrb,
    input  logic                   axi_wvalid,
    output logic                   axi_wready,

    output logic [1:0]             axi_bresp,
    output logic                   axi_bvalid,
    input  logic                   axi_bready,

    input  logic [AXIL_ADDR_W-1:0] axi_araddr,
    input  logic [2:0]             axi_arprot,
    input  logic                   axi_arvalid,
    output logic                   axi_arready,

    output logic [AXIL_DATA_W-1:0] axi_rdata,
    output logic [1:0]             axi_rresp,
    output logic                   axi_rvalid,
    input  logic                   axi_rready,

    output logic [NUM_REGS*32-1:0] regs_o,
    output logic [NUM_REGS-1:0]    wr_pulse_o
);

    localparam int                     IDX_W = $clog2(NUM_REGS);
    localparam logic [AXIL_ADDR_W-1:0] SPAN  = AXIL_ADDR_W'(NUM_REGS * 4);

    // Protection attributes carry no meaning for this bank.
    logic unused_prot;
    assign unused_prot = ^{axi_awprot, axi_arprot};

    // ------------------------------------------------------------------ write path
    logic                   aw_held;
    logic                   w_held;
    logic [AXIL_ADDR_W-1:0] aw_addr_q;
    logic [AXIL_DATA_W-1:0] w_data_q;
    logic [AXIL_STRB_W-1:0] w_strb_q;

    logic                   aw_hs;
    logic                   w_hs;
    logic                   commit;
    logic [AXIL_ADDR_W-1:0] wr_addr;
    logic [AXIL_DATA_W-1:0] wr_data;
    logic [AXIL_STRB_W-1:0] wr_strb;
    logic                   wr_in_range;
    logic [IDX_W-1:0]       wr_idx;

    assign axi_awready = !aw_held && !axi_bvalid;
    assign axi_wready  = !w_held && !axi_bvalid;

    assign aw_hs  = axi_awvalid && axi_awready;
    assign w_hs   = axi_wvalid && axi_wready;
    assign commit = (aw_held || aw_hs) && (w_held || w_hs);

    // A channel that arrived earlier supplies its captured value; otherwise the live bus.
    assign wr_addr = aw_held ? aw_addr_q : axi_awaddr;
    assign wr_data = w_held  ? w_data_q  : axi_wdata;
    assign wr_strb = w_held  ? w_strb_q  : axi_wstrb;

    assign wr_in_range = addr_in_range(wr_addr, BASE_ADDR, SPAN);
    assign wr_idx      = IDX_W'(reg_index(wr_addr, BASE_ADDR));

    always_ff @(posedge aclk) begin
        if (areset) begin
            aw_held    <= 1'b0;
            w_held     <= 1'b0;
            aw_addr_q  <= '0;
            w_data_q   <= '0;
            w_strb_q   <= '0;
            axi_bvalid <= 1'b0;
            axi_bresp  <= RESP_OKAY;
        end else begin
            if (commit) begin
                aw_held <= 1'b0;
                w_held  <= 1'b0;
            end else begin
                if (aw_hs) aw_held <= 1'b1;
                if (w_hs)  w_held  <= 1'b1;
            end

            if (aw_hs) aw_addr_q <= axi_awaddr;
            if (w_hs) begin
                w_data_q <= axi_wdata;
                w_strb_q <= axi_wstrb;
            end

            if (commit) begin
                axi_bvalid <= 1'b1;
                axi_bresp  <= wr_in_range ? RESP_OKAY : RESP_SLVERR;
            end else if (axi_bvalid && axi_bready) begin
                axi_bvalid <= 1'b0;
            end
        end
    end

    // ------------------------------------------------------------------ read path
    logic                   ar_hs;
    logic                   rd_in_range;
    logic [IDX_W-1:0]       rd_idx;
    logic [AXIL_DATA_W-1:0] rd_word;

    assign axi_arready = !axi_rvalid;
    assign ar_hs       = axi_arvalid && axi_arready;
    assign rd_in_range = addr_in_range(axi_araddr, BASE_ADDR, SPAN);
    assign rd_idx      = IDX_W'(reg_index(axi_araddr, BASE_ADDR));

    always_ff @(posedge aclk) begin
        if (areset) begin
            axi_rvalid <= 1'b0;
            axi_rdata  <= '0;
            axi_rresp  <= RESP_OKAY;
        end else if (ar_hs) begin
            axi_rvalid <= 1'b1;
            axi_rdata  <= rd_in_range ? rd_word : '0;
            axi_rresp  <= rd_in_range ? RESP_OKAY : RESP_SLVERR;
        end else if (axi_rvalid && axi_rready) begin
            axi_rvalid <= 1'b0;
        end
    end

    // ------------------------------------------------------------------ storage
    axil_reg_bank #(
        .NUM_REGS (NUM_REGS),
        .IDX_W    (IDX_W)
    ) u_bank (
        .clk      (aclk),
        .rst      (areset),
        .we       (commit && wr_in_range),
        .idx      (wr_idx),
        .data     (wr_data),
        .strb     (wr_strb),
        .rd_idx   (rd_idx),
        .rd_data  (rd_word),
        .regs     (regs_o),
        .wr_pulse (wr_pulse_o)
    );

endmodule

// File: tb/tb_axil_slave_regs.sv
// Self-checking bench for axil_slave_regs: directed scenarios plus randomized traffic
// compared against an array-based model of the register bank.
module tb_axil_slave_regs;

    localparam int          NUM_REGS = 16;
    localparam logic [31:0] BASE     = 32'h0000_0000;

    logic                   aclk = 1'b0;
    logic                   areset = 1'b0;
    logic [31:0]            axi_awaddr = '0;
    logic [2:0]             axi_awprot = '0;
    logic                   axi_awvalid = 1'b0;
    logic                   axi_awready;
    logic [31:0]            axi_wdata = '0;
    logic [3:0]             axi_wstrb = '0;
    logic                   axi_wvalid = 1'b0;
    logic                   axi_wready;
    logic [1:0]             axi_bresp;
    logic                   axi_bvalid;
    logic                   axi_bready = 1'b1;
    logic [31:0]            axi_araddr = '0;
    logic [2:0]             axi_arprot = '0;
    logic                   axi_arvalid = 1'b0;
    logic                   axi_arready;
    logic [31:0]            axi_rdata;
    logic [1:0]             axi_rresp;
    logic                   axi_rvalid;
    logic                   axi_rready = 1'b1;
    logic [NUM_REGS*32-1:0] regs_o;
    logic [NUM_REGS-1:0]    wr_pulse_o;

    int n_checks = 0;
    int n_errors = 0;

    logic [31:0] model [NUM_REGS];

    always #5 aclk = ~aclk;

    axil_slave_regs #(
        .NUM_REGS  (NUM_REGS),
        .BASE_ADDR (BASE)
    ) dut (
        .aclk        (aclk),
        .areset      (areset),
        .axi_awaddr  (axi_awaddr),
        .axi_awprot  (axi_awprot),
        .axi_awvalid (axi_awvalid),
        .axi_awready (axi_awready),
        .axi_wdata   (axi_wdata),
        .axi_wstrb   (axi_wstrb),
        .axi_wvalid  (axi_wvalid),
        .axi_wready  (axi_wready),
        .axi_bresp   (axi_bresp),
        .axi_bvalid  (axi_bvalid),
        .axi_bready  (axi_bready),
        .axi_araddr  (axi_araddr),
        .axi_arprot  (axi_arprot),
        .axi_arvalid (axi_arvalid),
        .axi_arready (axi_arready),
        .axi_rdata   (axi_rdata),
        .axi_rresp   (axi_rresp),
        .axi_rvalid  (axi_rvalid),
        .axi_rready  (axi_rready),
        .regs_o      (regs_o),
        .wr_pulse_o  (wr_pulse_o)
    );

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    function automatic bit exp_in_range(input logic [31:0] addr);
        return (addr - BASE) < 32'(NUM_REGS * 4);
    endfunction

    function automatic int exp_idx(input logic [31:0] addr);
        return int'((addr - BASE) / 4);
    endfunction

    function automatic logic [NUM_REGS*32-1:0] model_flat();
        logic [NUM_REGS*32-1:0] v;
        for (int i = 0; i < NUM_REGS; i++) v[32*i +: 32] = model[i];
        return v;
    endfunction

    task automatic model_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb);
        if (exp_in_range(addr)) begin
            for (int k = 0; k < 4; k++) begin
                if (strb[k]) model[exp_idx(addr)][8*k +: 8] = data[8*k +: 8];
            end
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < NUM_REGS; i++) model[i] = '0;
    endtask

    // Full write with AW and W offered after independent delays; bready held high.
    task automatic do_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                            input int aw_dly, input int w_dly);
        bit aw_done;
        bit w_done;
        bit aw_fire;
        bit w_fire;
        int c;
        logic [NUM_REGS-1:0] exp_pulse;
        logic [1:0] exp_resp;
        aw_done = 0;
        w_done = 0;
        c = 0;
        axi_awaddr = addr;
        axi_wdata = data;
        axi_wstrb = strb;
        axi_bready = 1'b1;
        while (!(aw_done && w_done) && c < 50) begin
            axi_awvalid = !aw_done && (c >= aw_dly);
            axi_wvalid = !w_done && (c >= w_dly);
            aw_fire = axi_awvalid && axi_awready;
            w_fire = axi_wvalid && axi_wready;
            tick();
            if (aw_fire) aw_done = 1;
            if (w_fire) w_done = 1;
            c++;
        end
        axi_awvalid = 1'b0;
        axi_wvalid = 1'b0;
        n_checks++;
        if (!(aw_done && w_done)) begin
            n_errors++;
            $display("FAIL write_handshake addr=%h: aw_done=%0d w_done=%0d, required both 1", addr, aw_done, w_done);
        end
        exp_pulse = '0;
        if (exp_in_range(addr)) exp_pulse[exp_idx(addr)] = 1'b1;
        exp_resp = exp_in_range(addr) ? 2'b00 : 2'b10;
        model_write(addr, data, strb);
        n_checks++;
        if (axi_bvalid !== 1'b1 || axi_bresp !== exp_resp) begin
            n_errors++;
            $display("FAIL write_resp addr=%h: bvalid=%b bresp=%b, required 1/%b", addr, axi_bvalid, axi_bresp, exp_resp);
        end
        n_checks++;
        if (wr_pulse_o !== exp_pulse) begin
            n_errors++;
            $display("FAIL write_pulse addr=%h: got %h, required %h", addr, wr_pulse_o, exp_pulse);
        end
        n_checks++;
        if (regs_o !== model_flat()) begin
            n_errors++;
            $display("FAIL write_regs addr=%h: got %h, required %h", addr, regs_o, model_flat());
        end
        tick();
        n_checks++;
        if (axi_bvalid !== 1'b0 || wr_pulse_o !== '0) begin
            n_errors++;
            $display("FAIL write_clear addr=%h: bvalid=%b pulse=%h, required 0/0", addr, axi_bvalid, wr_pulse_o);
        end
    endtask

    task automatic do_read(input logic [31:0] addr);
        bit fired;
        bit fire_now;
        int c;
        logic [31:0] exp_data;
        logic [1:0] exp_resp;
        fired = 0;
        c = 0;
        axi_araddr = addr;
        axi_arvalid = 1'b1;
        axi_rready = 1'b1;
        while (!fired && c < 50) begin
            fire_now = axi_arready;
            tick();
            if (fire_now) fired = 1;
            c++;
        end
        axi_arvalid = 1'b0;
        exp_data = exp_in_range(addr) ? model[exp_idx(addr)] : 32'h0;
        exp_resp = exp_in_range(addr) ? 2'b00 : 2'b10;
        n_checks++;
        if (!fired || axi_rvalid !== 1'b1 || axi_rdata !== exp_data || axi_rresp !== exp_resp) begin
            n_errors++;
            $display("FAIL read addr=%h: rvalid=%b rdata=%h rresp=%b, required 1/%h/%b",
                     addr, axi_rvalid, axi_rdata, axi_rresp, exp_data, exp_resp);
        end
        tick();
        n_checks++;
        if (axi_rvalid !== 1'b0) begin
            n_errors++;
            $display("FAIL read_clear addr=%h: rvalid=%b, required 0", addr, axi_rvalid);
        end
    endtask

    task automatic check_reset_values(input string tag);
        n_checks++;
        if ({axi_awready, axi_wready, axi_arready, axi_bvalid, axi_rvalid} !== 5'b11100) begin
            n_errors++;
            $display("FAIL %s_handshake: aw/w/ar ready,bvalid,rvalid=%b, required 11100", tag,
                     {axi_awready, axi_wready, axi_arready, axi_bvalid, axi_rvalid});
        end
        n_checks++;
        if ({axi_bresp, axi_rresp} !== 4'b0 || axi_rdata !== 32'h0) begin
            n_errors++;
            $display("FAIL %s_resp: bresp=%b rresp=%b rdata=%h, required zeros", tag, axi_bresp, axi_rresp, axi_rdata);
        end
        n_checks++;
        if (regs_o !== '0 || wr_pulse_o !== '0) begin
            n_errors++;
            $display("FAIL %s_regs: regs=%h pulse=%h, required zeros", tag, regs_o, wr_pulse_o);
        end
    endtask

    task automatic test_reset();
        areset = 1'b1;
        tick();
        tick();
        areset = 1'b0;
        model_clear();
        check_reset_values("reset");
    endtask

    task automatic test_same_cycle();
        do_write(32'h8, 32'hDEAD_BEEF, 4'hF, 0, 0);
        do_read(32'h8);
    endtask

    task automatic test_w_before_aw();
        axi_wdata = 32'h1122_3344;
        axi_wstrb = 4'b0101;
        axi_wvalid = 1'b1;
        axi_bready = 1'b1;
        tick();
        axi_wvalid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            n_checks++;
            if (axi_awready !== 1'b1 || axi_wready !== 1'b0 || axi_bvalid !== 1'b0) begin
                n_errors++;
                $display("FAIL w_held_ready cycle %0d: awready=%b wready=%b bvalid=%b, required 1/0/0",
                         i, axi_awready, axi_wready, axi_bvalid);
            end
            if (i < 2) tick();
        end
        axi_awaddr = 32'h0;
        axi_awvalid = 1'b1;
        tick();
        axi_awvalid = 1'b0;
        model_write(32'h0, 32'h1122_3344, 4'b0101);
        n_checks++;
        if (axi_bvalid !== 1'b1 || regs_o[31:0] !== 32'h0022_0044 || wr_pulse_o !== 16'h0001) begin
            n_errors++;
            $display("FAIL w_before_aw_commit: bvalid=%b reg0=%h pulse=%h, required 1/00220044/0001",
                     axi_bvalid, regs_o[31:0], wr_pulse_o);
        end
        tick();
        do_read(32'h0);
    endtask

    task automatic test_out_of_range();
        do_write(32'h40, 32'hCAFE_F00D, 4'hF, 0, 0);
        do_read(32'h40);
        do_read(32'h1000);
    endtask

    task automatic test_backpressure();
        logic [31:0] d1;
        logic [31:0] d2;
        d1 = $urandom;
        d2 = $urandom;
        axi_bready = 1'b0;
        axi_awaddr = 32'h14;
        axi_wdata = d1;
        axi_wstrb = 4'hF;
        axi_awvalid = 1'b1;
        axi_wvalid = 1'b1;
        tick();
        axi_wvalid = 1'b0;
        model_write(32'h14, d1, 4'hF);
        axi_awaddr = 32'h18;
        for (int i = 0; i < 5; i++) begin
            n_checks++;
            if (axi_bvalid !== 1'b1 || axi_bresp !== 2'b00 || axi_awready !== 1'b0 || axi_wready !== 1'b0) begin
                n_errors++;
                $display("FAIL b_stall cycle %0d: bvalid=%b bresp=%b awready=%b wready=%b, required 1/00/0/0",
                         i, axi_bvalid, axi_bresp, axi_awready, axi_wready);
            end
            tick();
        end
        axi_bready = 1'b1;
        tick();
        n_checks++;
        if (axi_bvalid !== 1'b0 || axi_awready !== 1'b1 || regs_o !== model_flat()) begin
            n_errors++;
            $display("FAIL b_release: bvalid=%b awready=%b regs=%h, required 0/1/%h",
                     axi_bvalid, axi_awready, regs_o, model_flat());
        end
        tick();
        axi_awvalid = 1'b0;
        n_checks++;
        if (axi_awready !== 1'b0 || axi_wready !== 1'b1 || axi_bvalid !== 1'b0) begin
            n_errors++;
            $display("FAIL aw_after_release: awready=%b wready=%b bvalid=%b, required 0/1/0",
                     axi_awready, axi_wready, axi_bvalid);
        end
        axi_wdata = d2;
        axi_wvalid = 1'b1;
        tick();
        axi_wvalid = 1'b0;
        model_write(32'h18, d2, 4'hF);
        n_checks++;
        if (axi_bvalid !== 1'b1 || regs_o !== model_flat() || wr_pulse_o !== 16'h0040) begin
            n_errors++;
            $display("FAIL second_commit: bvalid=%b pulse=%h regs=%h, required 1/0040/%h",
                     axi_bvalid, wr_pulse_o, regs_o, model_flat());
        end
        tick();
        axi_rready = 1'b0;
        axi_araddr = 32'h14;
        axi_arvalid = 1'b1;
        tick();
        axi_arvalid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            n_checks++;
            if (axi_rvalid !== 1'b1 || axi_rdata !== d1 || axi_rresp !== 2'b00 || axi_arready !== 1'b0) begin
                n_errors++;
                $display("FAIL r_stall cycle %0d: rvalid=%b rdata=%h rresp=%b arready=%b, required 1/%h/00/0",
                         i, axi_rvalid, axi_rdata, axi_rresp, axi_arready, d1);
            end
            tick();
        end
        axi_rready = 1'b1;
        tick();
        n_checks++;
        if (axi_rvalid !== 1'b0 || axi_arready !== 1'b1) begin
            n_errors++;
            $display("FAIL r_release: rvalid=%b arready=%b, required 0/1", axi_rvalid, axi_arready);
        end
    endtask

    task automatic test_collision();
        do_write(32'hC, 32'h5, 4'hF, 0, 0);
        axi_awaddr = 32'hC;
        axi_wdata = 32'h9;
        axi_wstrb = 4'hF;
        axi_araddr = 32'hC;
        axi_awvalid = 1'b1;
        axi_wvalid = 1'b1;
        axi_arvalid = 1'b1;
        tick();
        axi_awvalid = 1'b0;
        axi_wvalid = 1'b0;
        axi_arvalid = 1'b0;
        model_write(32'hC, 32'h9, 4'hF);
        n_checks++;
        if (axi_rvalid !== 1'b1 || axi_rdata !== 32'h5) begin
            n_errors++;
            $display("FAIL collision_read: rvalid=%b rdata=%h, required 1/00000005", axi_rvalid, axi_rdata);
        end
        n_checks++;
        if (axi_bvalid !== 1'b1 || regs_o[3*32 +: 32] !== 32'h9) begin
            n_errors++;
            $display("FAIL collision_write: bvalid=%b reg3=%h, required 1/00000009", axi_bvalid, regs_o[3*32 +: 32]);
        end
        tick();
        do_read(32'hC);
    endtask

    task automatic test_reset_mid();
        axi_awaddr = 32'h10;
        axi_awvalid = 1'b1;
        tick();
        axi_awvalid = 1'b0;
        axi_rready = 1'b0;
        axi_araddr = 32'h8;
        axi_arvalid = 1'b1;
        tick();
        axi_arvalid = 1'b0;
        n_checks++;
        if (axi_awready !== 1'b0 || axi_rvalid !== 1'b1) begin
            n_errors++;
            $display("FAIL pre_reset_state: awready=%b rvalid=%b, required 0/1", axi_awready, axi_rvalid);
        end
        areset = 1'b1;
        tick();
        model_clear();
        check_reset_values("mid_reset");
        areset = 1'b0;
        axi_rready = 1'b1;
        // A lone W must not pair with the dropped AW.
        axi_wdata = 32'hBAD0_BAD0;
        axi_wstrb = 4'hF;
        axi_wvalid = 1'b1;
        tick();
        axi_wvalid = 1'b0;
        tick();
        n_checks++;
        if (axi_bvalid !== 1'b0 || regs_o !== '0) begin
            n_errors++;
            $display("FAIL dropped_aw: bvalid=%b regs=%h, required 0/zeros", axi_bvalid, regs_o);
        end
        axi_awaddr = 32'h10;
        axi_awvalid = 1'b1;
        tick();
        axi_awvalid = 1'b0;
        model_write(32'h10, 32'hBAD0_BAD0, 4'hF);
        n_checks++;
        if (axi_bvalid !== 1'b1 || regs_o !== model_flat() || wr_pulse_o !== 16'h0010) begin
            n_errors++;
            $display("FAIL post_reset_write: bvalid=%b pulse=%h regs=%h, required 1/0010/%h",
                     axi_bvalid, wr_pulse_o, regs_o, model_flat());
        end
        tick();
        do_write(32'h24, $urandom, 4'hF, 1, 0);
        do_read(32'h24);
        do_read(32'h10);
    endtask

    task automatic test_random();
        logic [31:0] addr;
        for (int n = 0; n < 40; n++) begin
            addr = BASE + 32'(4 * $urandom_range(0, NUM_REGS + 3)) + 32'($urandom_range(0, 3));
            do_write(addr, $urandom, 4'($urandom), int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
            if ($urandom_range(0, 2) == 0) do_read(BASE + 32'(4 * $urandom_range(0, NUM_REGS + 1)));
        end
        for (int i = 0; i < NUM_REGS; i++) do_read(BASE + 32'(4 * i) + 32'($urandom_range(0, 3)));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "timeout");
    end

    initial begin
        model_clear();
        test_reset();
        test_same_cycle();
        test_w_before_aw();
        test_out_of_range();
        test_backpressure();
        test_collision();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
